// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Purpose:
//   Frame controller for the UART transmit path.  It accepts a parallel word,
//   holds it stable for the downstream serializer, sequences the serializer
//   through ser_en and drives the TX line level for each frame field
//   (start, data, optional parity, stop).
//
// Ports:
//   CLK         in   1           TX bit-rate clock
//   RST         in   1           asynchronous active-low reset
//   P_DATA      in   DATA_WIDTH  parallel word, sampled on accept
//   Data_Valid  in   1           request to send P_DATA
//   PAR_EN      in   1           1 = insert parity bit, sampled on accept
//   PAR_TYP     in   1           0 = even, 1 = odd, sampled on accept
//   ser_done    in   1           serializer has shifted its last data bit
//   ser_data    in   1           current serial data bit from the serializer
//   ser_en      out  1           serializer enable / load strobe
//   ser_p_data  out  DATA_WIDTH  latched word presented to the serializer
//   TX_OUT      out  1           serial line (idles high)
//   busy        out  1           frame in progress
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  TX_OUT,
    output logic                  busy
);

    // Frame states.  Encodings 5..7 are unused and fall back to IDLE.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Parity of a word; odd = 1 inverts the even-parity result.
    function automatic logic calc_parity(
        input logic [DATA_WIDTH-1:0] data,
        input logic                  odd
    );
        return (^data) ^ odd;
    endfunction

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bit;
    logic                  w_accept;
    logic                  w_tx_out;
    logic                  w_busy;
    logic                  w_ser_en;

    // New words are taken only when idle or during the stop bit; the stop
    // bit path gives back-to-back frames without an idle-high gap.
    always_comb begin
        w_accept = 1'b0;
        if (Data_Valid && ((r_state == IDLE) || (r_state == STOP))) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Next-state decode for the frame sequencer.
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                w_state_nxt = DATA;
            end
            DATA: begin
                // ser_done wins over any Data_Valid seen in this state.
                if (ser_done) begin
                    if (r_par_en) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY: begin
                w_state_nxt = STOP;
            end
            STOP: begin
                if (w_accept) begin
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture of the word and its parity settings at accept; held for the
    // whole frame so mid-frame input changes cannot disturb it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data    <= {DATA_WIDTH{1'b0}};
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_par_bit <= calc_parity(P_DATA, PAR_TYP);
        end else begin
            r_data    <= r_data;
            r_par_en  <= r_par_en;
            r_par_typ <= r_par_typ;
            r_par_bit <= r_par_bit;
        end
    end

    // Moore output decode; only the DATA state passes the serializer bit
    // straight through so the line follows the shifter with no extra delay.
    always_comb begin
        w_tx_out = 1'b1;
        w_busy   = 1'b0;
        w_ser_en = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_out = 1'b1;
                w_busy   = 1'b0;
                w_ser_en = 1'b0;
            end
            START: begin
                w_tx_out = 1'b0;
                w_busy   = 1'b1;
                w_ser_en = 1'b1;
            end
            DATA: begin
                w_tx_out = ser_data;
                w_busy   = 1'b1;
                w_ser_en = 1'b1;
            end
            PARITY: begin
                w_tx_out = r_par_bit;
                w_busy   = 1'b1;
                w_ser_en = 1'b0;
            end
            STOP: begin
                w_tx_out = 1'b1;
                w_busy   = 1'b1;
                w_ser_en = 1'b0;
            end
            default: begin
                w_tx_out = 1'b1;
                w_busy   = 1'b0;
                w_ser_en = 1'b0;
            end
        endcase
    end

    assign TX_OUT     = w_tx_out;
    assign busy       = w_busy;
    assign ser_en     = w_ser_en;
    assign ser_p_data = r_data;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Self-checking bench for uart_tx_ctrl.  A behavioural serializer loads
// ser_p_data when ser_en rises and shifts it out LSB first, flagging
// ser_done on the last bit.  Expected {ser_en, TX_OUT, busy} triples are
// pushed into a scoreboard queue when a request is driven and popped and
// compared each cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          ser_done;
    logic          ser_data;
    logic          ser_en;
    logic [DW-1:0] ser_p_data;
    logic          TX_OUT;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] sb_q[$];
    logic [2:0] exp_v;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .ser_p_data (ser_p_data),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Behavioural serializer.
    logic [DW-1:0] sh;
    logic [3:0]    cnt;
    logic          active;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh     <= '0;
            cnt    <= 4'd0;
            active <= 1'b0;
        end else if (ser_en && !active) begin
            sh     <= ser_p_data;
            cnt    <= 4'd0;
            active <= 1'b1;
        end else if (active) begin
            sh  <= sh >> 1;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) active <= 1'b0;
        end
    end

    assign ser_data = sh[0];
    assign ser_done = active && (cnt == 4'd7);

    // Push the expected {ser_en, TX_OUT, busy} sequence of one frame.
    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        sb_q.push_back(3'b101);
        for (int i = 0; i < DW; i++) sb_q.push_back({1'b1, d[i], 1'b1});
        if (pe) sb_q.push_back({1'b0, (^d) ^ pt, 1'b1});
        sb_q.push_back(3'b011);
    endtask

    // Drive a request on the falling edge and record its expected frame.
    task automatic start_req(input logic [DW-1:0] d, input logic pe, input logic pt);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        push_frame(d, pe, pt);
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        n_tests++;
        if ({ser_en, TX_OUT, busy, ser_p_data} !== {3'b010, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_values: got %b/%h expected 010/00", {ser_en, TX_OUT, busy}, ser_p_data);
        end
        RST = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== 3'b010) begin
                n_fail++;
                $display("FAIL idle c%0d: got %b expected 010", c, {ser_en, TX_OUT, busy});
            end
        end
    endtask

    task automatic test_even_parity;
        start_req(8'hA5, 1'b1, 1'b0);
        for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
            @(negedge CLK);
            if (c == 0) Data_Valid = 1'b0;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== exp_v || ser_p_data !== 8'hA5) begin
                n_fail++;
                $display("FAIL even_parity c%0d: got %b/%h expected %b/a5", c, {ser_en, TX_OUT, busy}, ser_p_data, exp_v);
            end
        end
        @(negedge CLK);
        n_tests++;
        if ({ser_en, TX_OUT, busy} !== 3'b010 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL even_parity_end: got %b expected 010 (left %0d)", {ser_en, TX_OUT, busy}, sb_q.size());
        end
    endtask

    task automatic test_odd_parity;
        start_req(8'h01, 1'b1, 1'b1);
        for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
            @(negedge CLK);
            if (c == 0) Data_Valid = 1'b0;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL odd_parity c%0d: got %b expected %b", c, {ser_en, TX_OUT, busy}, exp_v);
            end
        end
        // Parity slot of 8'h01 odd is 0: spot-check the length as well.
        @(negedge CLK);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_parity_len: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_parity_off;
        int len;
        len = 0;
        start_req(8'h01, 1'b0, 1'b1);
        for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
            @(negedge CLK);
            if (c == 0) Data_Valid = 1'b0;
            exp_v = sb_q.pop_front();
            if (busy === 1'b1) len++;
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL parity_off c%0d: got %b expected %b", c, {ser_en, TX_OUT, busy}, exp_v);
            end
        end
        @(negedge CLK);
        if (busy === 1'b1) len++;
        n_tests++;
        if (len != 10) begin
            n_fail++;
            $display("FAIL parity_off_len: got %0d busy cycles expected 10", len);
        end
    endtask

    task automatic test_back_to_back;
        start_req(8'h81, 1'b0, 1'b0);
        for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
            @(negedge CLK);
            if (c == 0 || c == 10) Data_Valid = 1'b0;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got %b expected %b", c, {ser_en, TX_OUT, busy}, exp_v);
            end
            if (c >= 10) begin
                n_tests++;
                if (ser_p_data !== 8'h3C) begin
                    n_fail++;
                    $display("FAIL b2b_data c%0d: got %h expected 3c", c, ser_p_data);
                end
            end
            if (c == 9) begin
                // Request during the stop bit of the first frame.
                P_DATA     = 8'h3C;
                PAR_EN     = 1'b1;
                PAR_TYP    = 1'b0;
                Data_Valid = 1'b1;
                push_frame(8'h3C, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic test_ignored_request;
        start_req(8'h96, 1'b1, 1'b0);
        for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
            @(negedge CLK);
            if (c == 0 || c == 4) Data_Valid = 1'b0;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== exp_v || ser_p_data !== 8'h96) begin
                n_fail++;
                $display("FAIL ignored_req c%0d: got %b/%h expected %b/96", c, {ser_en, TX_OUT, busy}, ser_p_data, exp_v);
            end
            if (c == 3) begin
                P_DATA     = 8'hFF;
                PAR_TYP    = 1'b1;
                PAR_EN     = 1'b0;
                Data_Valid = 1'b1;
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== 3'b010 || ser_p_data !== 8'h96) begin
                n_fail++;
                $display("FAIL no_second_frame c%0d: got %b/%h expected 010/96", c, {ser_en, TX_OUT, busy}, ser_p_data);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        start_req(8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
            @(negedge CLK);
            if (c == 0) Data_Valid = 1'b0;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL pre_abort c%0d: got %b expected %b", c, {ser_en, TX_OUT, busy}, exp_v);
            end
            if (c == 4) begin
                // 4th data bit on the line: abort asynchronously.
                #1 RST = 1'b0;
                #1;
                n_tests++;
                if ({ser_en, TX_OUT, busy, ser_p_data} !== {3'b010, 8'h00}) begin
                    n_fail++;
                    $display("FAIL async_abort: got %b/%h expected 010/00", {ser_en, TX_OUT, busy}, ser_p_data);
                end
                sb_q.delete();
                break;
            end
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        start_req(8'h55, 1'b1, 1'b1);
        for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
            @(negedge CLK);
            if (c == 0) Data_Valid = 1'b0;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({ser_en, TX_OUT, busy} !== exp_v || ser_p_data !== 8'h55) begin
                n_fail++;
                $display("FAIL post_reset c%0d: got %b/%h expected %b/55", c, {ser_en, TX_OUT, busy}, ser_p_data, exp_v);
            end
        end
        @(negedge CLK);
        n_tests++;
        if ({ser_en, TX_OUT, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL post_reset_end: got %b expected 010", {ser_en, TX_OUT, busy});
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_parity_off();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
